// File: rtl/adma_pkg.sv
// Shared definitions for the ADMA descriptor path: line width, field bit positions,
// ACT codes and the one-hot fetch FSM state encoding.
package adma_pkg;

  localparam int unsigned DESC_W = 96;

  localparam int unsigned ATTR_VALID_BIT = 0;
  localparam int unsigned ATTR_END_BIT   = 1;
  localparam int unsigned ATTR_INT_BIT   = 2;
  localparam int unsigned ACT_LSB        = 4;
  localparam int unsigned ACT_MSB        = 5;
  localparam int unsigned LEN_LSB        = 16;
  localparam int unsigned LEN_MSB        = 31;
  localparam int unsigned ADR_LSB        = 32;
  localparam int unsigned ADR_MSB        = 95;

  typedef enum logic [1:0] {
    ActNop  = 2'b00,
    ActRsv  = 2'b01,
    ActTran = 2'b10,
    ActLink = 2'b11
  } adma_act_e;

  typedef enum logic [5:0] {
    StIdle = 6'b000001,
    StRd0  = 6'b000010,
    StRd1  = 6'b000100,
    StRd2  = 6'b001000,
    StHold = 6'b010000,
    StErr  = 6'b100000
  } fetch_state_e;

  // Byte address of descriptor word idx; wraps modulo 2^64.
  function automatic logic [63:0] word_addr(input logic [63:0] base, input logic [1:0] idx);
    return base + {60'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/adma_desc_parse.sv
// Pure combinational decode of a 96-bit ADMA descriptor line into its fields.
// The Valid attribute is passed through untouched; the ADMA engine decides what it means.
module adma_desc_parse
  import adma_pkg::*;
(
  input  logic [DESC_W-1:0] desc_line,
  output logic              desc_attr_valid,
  output logic              desc_end,
  output logic              desc_int,
  output logic [1:0]        desc_act,
  output logic [15:0]       desc_len,
  output logic [63:0]       desc_adr
);

  assign desc_attr_valid = desc_line[ATTR_VALID_BIT];
  assign desc_end        = desc_line[ATTR_END_BIT];
  assign desc_int        = desc_line[ATTR_INT_BIT];
  assign desc_act        = desc_line[ACT_MSB:ACT_LSB];
  assign desc_len        = desc_line[LEN_MSB:LEN_LSB];
  assign desc_adr        = desc_line[ADR_MSB:ADR_LSB];

endmodule

// File: rtl/adma_descriptor_fetch.sv
// Fetches one 96-bit ADMA descriptor as three 32-bit reads and holds it for the engine.
// Define ADMA_ALIGN_CHECK_EN to reject fetch addresses that are not 8-byte aligned.
module adma_descriptor_fetch
  import adma_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [63:0]       fetch_addr,
  input  logic              fetch_abort,
  output logic              fetch_busy,
  output logic              mem_rd_req,
  output logic [63:0]       mem_addr,
  input  logic              mem_rd_ack,
  input  logic [31:0]       mem_rd_data,
  input  logic              mem_err,
  output logic              desc_valid,
  input  logic              desc_ready,
  output logic [DESC_W-1:0] desc_line,
  output logic              desc_attr_valid,
  output logic              desc_end,
  output logic              desc_int,
  output logic [1:0]        desc_act,
  output logic [15:0]       desc_len,
  output logic [63:0]       desc_adr,
  output logic              fetch_error
);

  localparam logic [7:0] WaitLast = 8'(TIMEOUT_CYCLES - 1);

  fetch_state_e      state_q, state_d;
  logic [63:0]       base_q;
  logic [7:0]        wait_q, wait_d;
  logic [DESC_W-1:0] line_q, line_d;
  logic [63:0]       capture_addr;
  logic              misaligned;
  logic              capture;
  logic              in_rd;
  logic [1:0]        word_idx;

`ifdef ADMA_ALIGN_CHECK_EN
  assign misaligned   = |fetch_addr[2:0];
  assign capture_addr = fetch_addr;
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^fetch_addr[2:0];
  assign misaligned      = 1'b0;
  assign capture_addr    = {fetch_addr[63:3], 3'b000};
`endif

  assign in_rd   = (state_q == StRd0) || (state_q == StRd1) || (state_q == StRd2);
  assign capture = (state_q == StIdle) && fetch_req && !misaligned;

  always_comb begin
    word_idx = 2'd0;
    if (state_q == StRd1) word_idx = 2'd1;
    if (state_q == StRd2) word_idx = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Priority inside a read: abort, then bus error, then ack, then timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (fetch_req) state_d = misaligned ? StErr : StRd0;
      end
      StRd0, StRd1, StRd2: begin
        if (fetch_abort) begin
          state_d = StIdle;
        end else if (mem_err) begin
          state_d = StErr;
        end else if (mem_rd_ack) begin
          state_d = (state_q == StRd0) ? StRd1 : (state_q == StRd1) ? StRd2 : StHold;
        end else if (wait_q == WaitLast) begin
          state_d = StErr;
        end
      end
      StHold: begin
        if (fetch_abort || desc_ready) state_d = StIdle;
      end
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fetch_busy  = (state_q != StIdle);
    mem_rd_req  = in_rd;
    mem_addr    = in_rd ? word_addr(base_q, word_idx) : 64'd0;
    desc_valid  = (state_q == StHold);
    fetch_error = (state_q == StErr);
  end

  // Counter is zero outside reads, so entering RD0 and every ack both restart it.
  always_comb begin
    wait_d = 8'd0;
    if (in_rd && !mem_rd_ack) wait_d = wait_q + 8'd1;
  end

  always_comb begin
    line_d = line_q;
    if (in_rd && mem_rd_ack && !mem_err && !fetch_abort) begin
      case (word_idx)
        2'd0:    line_d[31:0]  = mem_rd_data;
        2'd1:    line_d[63:32] = mem_rd_data;
        default: line_d[95:64] = mem_rd_data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= 64'd0;
      wait_q <= 8'd0;
      line_q <= '0;
    end else begin
      if (capture) base_q <= capture_addr;
      wait_q <= wait_d;
      line_q <= line_d;
    end
  end

  assign desc_line = line_q;

  adma_desc_parse u_parse (
    .desc_line       (line_q),
    .desc_attr_valid (desc_attr_valid),
    .desc_end        (desc_end),
    .desc_int        (desc_int),
    .desc_act        (desc_act),
    .desc_len        (desc_len),
    .desc_adr        (desc_adr)
  );

endmodule

// File: tb/tb_adma_descriptor_fetch.sv
// Self-checking bench for adma_descriptor_fetch: directed scenarios plus randomized fetches
// checked against a behavioural model of the three-word descriptor fetch.
module tb_adma_descriptor_fetch;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset, fetch_req, fetch_abort, mem_rd_ack, mem_err, desc_ready;
  logic [63:0] fetch_addr;
  logic [31:0] mem_rd_data;
  logic        fetch_busy, mem_rd_req, desc_valid, fetch_error;
  logic [63:0] mem_addr, desc_adr;
  logic [95:0] desc_line;
  logic        desc_attr_valid, desc_end, desc_int;
  logic [1:0]  desc_act;
  logic [15:0] desc_len;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem_word [3];

  // Observations from run_fetch
  int          obs_valid_cyc;
  logic [63:0] obs_addr [3];
  logic [95:0] obs_line;
  logic [86:0] obs_fields;
  logic        obs_stable, obs_err, obs_idle_after, obs_overlap, obs_addr_moved;

  always #5 clk = ~clk;

  adma_descriptor_fetch #(.TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_req       (fetch_req),
    .fetch_addr      (fetch_addr),
    .fetch_abort     (fetch_abort),
    .fetch_busy      (fetch_busy),
    .mem_rd_req      (mem_rd_req),
    .mem_addr        (mem_addr),
    .mem_rd_ack      (mem_rd_ack),
    .mem_rd_data     (mem_rd_data),
    .mem_err         (mem_err),
    .desc_valid      (desc_valid),
    .desc_ready      (desc_ready),
    .desc_line       (desc_line),
    .desc_attr_valid (desc_attr_valid),
    .desc_end        (desc_end),
    .desc_int        (desc_int),
    .desc_act        (desc_act),
    .desc_len        (desc_len),
    .desc_adr        (desc_adr),
    .fetch_error     (fetch_error)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bus and consumer model: ack each word after ack_delay wait cycles, raise desc_ready after
  // ready_delay cycles of desc_valid.
  task automatic run_fetch(input logic [63:0] addr, input int ack_delay, input int ready_delay);
    int   cyc, word_n, wait_n, hold_n;
    logic done;
    obs_valid_cyc = -1; obs_stable = 1'b1; obs_err = 1'b0; obs_overlap = 1'b0;
    obs_addr_moved = 1'b0; obs_line = '0; obs_fields = '0;
    for (int i = 0; i < 3; i++) obs_addr[i] = '1;
    fetch_req = 1'b1; fetch_addr = addr;
    step();
    fetch_req = 1'b0; fetch_addr = {$urandom(), $urandom()};
    cyc = 1; word_n = 0; wait_n = 0; hold_n = 0; done = 1'b0;
    while (!done && cyc < 100) begin
      mem_rd_ack = 1'b0; mem_rd_data = $urandom(); desc_ready = 1'b0;
      if (mem_rd_req && word_n < 3) begin
        if (wait_n == 0) obs_addr[word_n] = mem_addr;
        else if (mem_addr !== obs_addr[word_n]) obs_addr_moved = 1'b1;
        if (wait_n == ack_delay) begin
          mem_rd_ack = 1'b1; mem_rd_data = mem_word[word_n]; word_n++; wait_n = 0;
        end else begin
          wait_n++;
        end
      end
      if (desc_valid) begin
        if (mem_rd_req) obs_overlap = 1'b1;
        if (hold_n == 0) begin
          obs_valid_cyc = cyc; obs_line = desc_line;
          obs_fields = {desc_attr_valid, desc_end, desc_int, desc_act, desc_len, desc_adr};
        end else if (desc_line !== obs_line || obs_fields !==
                     {desc_attr_valid, desc_end, desc_int, desc_act, desc_len, desc_adr}) begin
          obs_stable = 1'b0;
        end
        if (hold_n >= ready_delay) begin
          desc_ready = 1'b1; done = 1'b1;
        end
        hold_n++;
      end
      if (fetch_error) obs_err = 1'b1;
      step();
      cyc++;
    end
    mem_rd_ack = 1'b0; desc_ready = 1'b0;
    obs_idle_after = done && !fetch_busy && !desc_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1; fetch_req = 1'b0; fetch_abort = 1'b0; mem_rd_ack = 1'b0; mem_err = 1'b0;
    desc_ready = 1'b0; fetch_addr = '0; mem_rd_data = '0;
    step(); step();
    n_cmp++;
    if ({fetch_busy, mem_rd_req, desc_valid, fetch_error} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got busy/req/valid/err=%b, want 0000",
               {fetch_busy, mem_rd_req, desc_valid, fetch_error});
    end
    n_cmp++;
    if (mem_addr !== 64'd0 || desc_line !== 96'd0) begin
      n_bad++;
      $display("FAIL reset_data: got addr=%h line=%h, want 0", mem_addr, desc_line);
    end
    n_cmp++;
    if ({desc_attr_valid, desc_end, desc_int, desc_act, desc_len, desc_adr} !== 87'd0) begin
      n_bad++;
      $display("FAIL reset_fields: got nonzero field outputs len=%h adr=%h", desc_len, desc_adr);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if (fetch_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: got busy=%b, want 0", fetch_busy);
    end
  endtask

  task automatic test_zero_wait();
    mem_word[0] = 32'h0010_0021; mem_word[1] = 32'h8000_0000; mem_word[2] = 32'h0000_0001;
    run_fetch(64'h1000, 0, 0);
    n_cmp++;
    if ({obs_addr[0], obs_addr[1], obs_addr[2]} !== {64'h1000, 64'h1004, 64'h1008}) begin
      n_bad++;
      $display("FAIL zw_addr: got %h %h %h, want 1000 1004 1008",
               obs_addr[0], obs_addr[1], obs_addr[2]);
    end
    n_cmp++;
    if (obs_valid_cyc != 4) begin
      n_bad++;
      $display("FAIL zw_latency: got desc_valid at cycle %0d, want 4", obs_valid_cyc);
    end
    n_cmp++;
    if (obs_fields !== {1'b1, 1'b0, 1'b0, 2'b10, 16'h0010, 64'h1_8000_0000}) begin
      n_bad++;
      $display("FAIL zw_fields: got %h, want act=10 end=0 valid=1 len=0010 adr=180000000",
               obs_fields);
    end
    n_cmp++;
    if (!obs_idle_after || obs_err || obs_overlap) begin
      n_bad++;
      $display("FAIL zw_done: got idle=%b err=%b overlap=%b, want 1 0 0",
               obs_idle_after, obs_err, obs_overlap);
    end
  endtask

  task automatic test_slow_ready();
    mem_word[0] = 32'hBEEF_0036; mem_word[1] = 32'h1234_5678; mem_word[2] = 32'h9ABC_DEF0;
    run_fetch(64'h0000_0040_0000_2000, 3, 5);
    n_cmp++;
    if (obs_valid_cyc != 13 || obs_line !== {mem_word[2], mem_word[1], mem_word[0]}) begin
      n_bad++;
      $display("FAIL slow_line: got cycle %0d line %h, want 13 %h", obs_valid_cyc, obs_line,
               {mem_word[2], mem_word[1], mem_word[0]});
    end
    n_cmp++;
    if (!obs_stable || obs_addr_moved || !obs_idle_after || obs_err) begin
      n_bad++;
      $display("FAIL slow_hold: got stable=%b moved=%b idle=%b err=%b, want 1 0 1 0",
               obs_stable, obs_addr_moved, obs_idle_after, obs_err);
    end
  endtask

  task automatic test_random();
    logic [63:0] addr, base, ea [3];
    int          ad, rd;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 3; i++) mem_word[i] = $urandom();
      addr = {$urandom(), $urandom()};
`ifdef ADMA_ALIGN_CHECK_EN
      addr[2:0] = 3'b000;
`endif
      base = addr & ~64'd7;
      for (int i = 0; i < 3; i++) ea[i] = base + 64'(4 * i);
      ad = $urandom_range(0, 3); rd = $urandom_range(0, 3);
      run_fetch(addr, ad, rd);
      n_cmp++;
      if ({obs_addr[0], obs_addr[1], obs_addr[2]} !== {ea[0], ea[1], ea[2]} || obs_addr_moved)
      begin
        n_bad++;
        $display("FAIL rnd_addr[%0d]: got %h %h %h, want %h %h %h", it, obs_addr[0],
                 obs_addr[1], obs_addr[2], ea[0], ea[1], ea[2]);
      end
      n_cmp++;
      if (obs_valid_cyc != 1 + 3 * (ad + 1) ||
          obs_line !== {mem_word[2], mem_word[1], mem_word[0]}) begin
        n_bad++;
        $display("FAIL rnd_line[%0d]: got cycle %0d line %h, want %0d %h", it, obs_valid_cyc,
                 obs_line, 1 + 3 * (ad + 1), {mem_word[2], mem_word[1], mem_word[0]});
      end
      n_cmp++;
      if (obs_fields !== {mem_word[0][0], mem_word[0][1], mem_word[0][2], mem_word[0][5:4],
                          mem_word[0][31:16], mem_word[2], mem_word[1]}) begin
        n_bad++;
        $display("FAIL rnd_fields[%0d]: got %h from word0 %h", it, obs_fields, mem_word[0]);
      end
      n_cmp++;
      if (!obs_stable || !obs_idle_after || obs_err || obs_overlap) begin
        n_bad++;
        $display("FAIL rnd_flow[%0d]: got stable=%b idle=%b err=%b overlap=%b", it,
                 obs_stable, obs_idle_after, obs_err, obs_overlap);
      end
    end
  endtask

  task automatic test_mem_err();
    int          n_err, err_cyc, word_n;
    logic        saw_valid, req_in_err, busy_in_err;
    logic [63:0] upper_before;
    upper_before = desc_line[95:32];
    fetch_req = 1'b1; fetch_addr = 64'h2000;
    step();
    fetch_req = 1'b0;
    n_err = 0; err_cyc = -1; word_n = 0; saw_valid = 1'b0; req_in_err = 1'b0;
    busy_in_err = 1'b0;
    for (int cyc = 1; cyc < 10; cyc++) begin
      mem_rd_ack = 1'b0; mem_err = 1'b0;
      if (mem_rd_req) begin
        mem_rd_ack = 1'b1; mem_rd_data = ~upper_before[31:0];
        if (word_n == 1) mem_err = 1'b1;
        word_n++;
      end
      if (desc_valid) saw_valid = 1'b1;
      if (fetch_error) begin
        n_err++; err_cyc = cyc; req_in_err = mem_rd_req; busy_in_err = fetch_busy;
      end
      step();
    end
    mem_rd_ack = 1'b0; mem_err = 1'b0;
    n_cmp++;
    if (n_err != 1 || err_cyc != 3) begin
      n_bad++;
      $display("FAIL err_pulse: got %0d pulses, last at cycle %0d, want 1 at 3", n_err, err_cyc);
    end
    n_cmp++;
    if (saw_valid || req_in_err || !busy_in_err || fetch_busy) begin
      n_bad++;
      $display("FAIL err_flow: got valid=%b req_in_err=%b busy_in_err=%b busy=%b, want 0 0 1 0",
               saw_valid, req_in_err, busy_in_err, fetch_busy);
    end
    n_cmp++;
    if (desc_line[95:32] !== upper_before) begin
      n_bad++;
      $display("FAIL err_discard: got upper line %h, want %h", desc_line[95:32], upper_before);
    end
  endtask

  task automatic test_timeout_wrap();
    logic [63:0] a [3];
    int          err_cyc, n_err, word_n;
    for (int pass = 0; pass < 2; pass++) begin
      fetch_req = 1'b1;
      fetch_addr = (pass == 0) ? 64'h0000_1230 : 64'hFFFF_FFFF_FFFF_FFF8;
      step();
      fetch_req = 1'b0;
      err_cyc = -1; n_err = 0; word_n = 0;
      for (int i = 0; i < 3; i++) a[i] = '1;
      for (int cyc = 1; cyc < 16; cyc++) begin
        mem_rd_ack = 1'b0;
        if (mem_rd_req && word_n < 3) begin
          a[word_n] = mem_addr;
          if (pass == 1 && word_n < 2) begin
            mem_rd_ack = 1'b1; mem_rd_data = $urandom(); word_n++;
          end
        end
        if (fetch_error) begin
          n_err++; err_cyc = cyc;
        end
        step();
      end
      mem_rd_ack = 1'b0;
      n_cmp++;
      if (n_err != 1 || err_cyc != ((pass == 0) ? 1 + TO : 3 + TO)) begin
        n_bad++;
        $display("FAIL timeout[%0d]: got %0d pulses at cycle %0d, want 1 at %0d", pass, n_err,
                 err_cyc, (pass == 0) ? 1 + TO : 3 + TO);
      end
      if (pass == 1) begin
        n_cmp++;
        if ({a[0], a[1], a[2]} !== {64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0})
        begin
          n_bad++;
          $display("FAIL wrap_addr: got %h %h %h, want ..FFF8 ..FFFC 0", a[0], a[1], a[2]);
        end
      end
    end
  endtask

  task automatic test_abort();
    int   word_n;
    logic aborted, bad_after;
    for (int s = 0; s < 2; s++) begin
      fetch_req = 1'b1; fetch_addr = 64'h3000;
      step();
      fetch_req = 1'b0;
      word_n = 0; aborted = 1'b0;
      for (int cyc = 1; cyc < 12 && !aborted; cyc++) begin
        mem_rd_ack = 1'b0; desc_ready = 1'b0;
        if (mem_rd_req) begin
          mem_rd_ack = 1'b1; mem_rd_data = $urandom();
          if (s == 0 && word_n == 2) begin
            fetch_abort = 1'b1; aborted = 1'b1;
          end
          word_n++;
        end
        if (s == 1 && desc_valid) begin
          fetch_abort = 1'b1; aborted = 1'b1;
        end
        step();
      end
      fetch_abort = 1'b0; mem_rd_ack = 1'b0;
      n_cmp++;
      if (!aborted || {fetch_busy, desc_valid, mem_rd_req, fetch_error} !== 4'b0) begin
        n_bad++;
        $display("FAIL abort[%0d]: got reached=%b busy/valid/req/err=%b, want 1 0000", s,
                 aborted, {fetch_busy, desc_valid, mem_rd_req, fetch_error});
      end
      bad_after = 1'b0;
      repeat (3) begin
        if (fetch_error || desc_valid || fetch_busy) bad_after = 1'b1;
        step();
      end
      n_cmp++;
      if (bad_after) begin
        n_bad++;
        $display("FAIL abort_quiet[%0d]: got activity after abort, want none", s);
      end
    end
  endtask

  task automatic test_reset_mid();
    fetch_req = 1'b1; fetch_addr = 64'h4000;
    step();
    fetch_req = 1'b0; mem_rd_ack = 1'b1; mem_rd_data = 32'hA5A5_5A5A;
    step();
    n_cmp++;
    if (mem_rd_req !== 1'b1 || mem_addr !== 64'h4004) begin
      n_bad++;
      $display("FAIL rst_pre: got req=%b addr=%h, want 1 4004", mem_rd_req, mem_addr);
    end
    reset = 1'b1;
    step();
    reset = 1'b0; mem_rd_ack = 1'b0;
    n_cmp++;
    if ({fetch_busy, mem_rd_req, desc_valid, fetch_error} !== 4'b0 || mem_addr !== 64'd0 ||
        desc_line !== 96'd0) begin
      n_bad++;
      $display("FAIL rst_mid: got busy/req/valid/err=%b addr=%h line=%h, want all 0",
               {fetch_busy, mem_rd_req, desc_valid, fetch_error}, mem_addr, desc_line);
    end
  endtask

  task automatic test_align();
    fetch_req = 1'b1; fetch_addr = 64'h1004;
    step();
    fetch_req = 1'b0;
    n_cmp++;
`ifdef ADMA_ALIGN_CHECK_EN
    if (fetch_error !== 1'b1 || mem_rd_req !== 1'b0) begin
      n_bad++;
      $display("FAIL align: got err=%b req=%b, want 1 0", fetch_error, mem_rd_req);
    end
`else
    if (mem_rd_req !== 1'b1 || mem_addr !== 64'h1000 || fetch_error !== 1'b0) begin
      n_bad++;
      $display("FAIL align: got req=%b addr=%h err=%b, want 1 1000 0", mem_rd_req, mem_addr,
               fetch_error);
    end
    fetch_abort = 1'b1;
    step();
    fetch_abort = 1'b0;
`endif
    repeat (2) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_slow_ready();
    test_random();
    test_mem_err();
    test_timeout_wrap();
    test_abort();
    test_reset_mid();
    test_align();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adma_descriptor_fetch.md
ADMA_DESCRIPTOR_FETCH -- requirements
Module: adma_descriptor_fetch

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max cycles without mem_rd_ack per word before error (1..255).
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 fetch_req  input  1  request descriptor fetch at fetch_addr.
REQ-005 fetch_addr  input  64  system address of descriptor line (SYS_ADR).
REQ-006 fetch_abort  input  1  abandon fetch in progress (Stop At Block Gap / stop).
REQ-007 fetch_busy  output  1  high in every state except IDLE.
REQ-008 mem_rd_req  output  1  32-bit memory read request.
REQ-009 mem_addr  output  64  read address, stable while mem_rd_req high.
REQ-010 mem_rd_ack  input  1  read data valid this cycle.
REQ-011 mem_rd_data  input  32  read data.
REQ-012 mem_err  input  1  bus error on current read.
REQ-013 desc_valid  output  1  descriptor outputs valid.
REQ-014 desc_ready  input  1  ADMA state machine accepts descriptor.
REQ-015 desc_line  output  96  assembled descriptor line.
REQ-016 desc_attr_valid, desc_end, desc_int  output  1 each  desc_line bits 0, 1, 2.
REQ-017 desc_act  output  2  desc_line[5:4].
REQ-018 desc_len  output  16  desc_line[31:16]; desc_adr output 64 desc_line[95:32].
REQ-019 fetch_error  output  1  one-cycle pulse: bus error, timeout or misalignment.

Function
REQ-020 States IDLE, RD0, RD1, RD2, HOLD, ERR; one-hot encoded.
REQ-021 IDLE: fetch_req=1 captures fetch_addr into base register, next state RD0; fetch_req ignored in all other states.
REQ-022 RDn (n=0,1,2): mem_rd_req=1, mem_addr=base+4n (modulo 2^64, wraps); on mem_rd_ack, mem_rd_data stored to desc_line[32n+31:32n], advance to next RD or HOLD.
REQ-023 mem_rd_req stays high across RD0->RD1->RD2; mem_addr changes only in cycle after an ack.
REQ-024 Zero-wait bus (ack in request cycle): acceptance at cycle 0, desc_valid=1 at cycle 4.
REQ-025 HOLD: desc_valid=1, desc_line and fields stable until desc_valid&&desc_ready; then IDLE next cycle.
REQ-026 Field outputs are pure decodes of desc_line; no check of Valid bit (ADMA engine owns that).
REQ-027 8-bit wait counter clears on entering each RDn and on ack; reaching TIMEOUT_CYCLES without ack -> ERR.
REQ-028 mem_err=1 in RDn -> ERR; mem_err beats mem_rd_ack in same cycle, data discarded.
REQ-029 ERR: fetch_error=1 for exactly one cycle, mem_rd_req=0, then IDLE.
REQ-030 fetch_abort=1 in RDn/HOLD -> IDLE next cycle, no fetch_error; abort beats ack/err same cycle.
REQ-031 fetch_abort with desc_valid&&desc_ready in HOLD: transfer counts as done, IDLE next.
REQ-032 desc_valid never high outside HOLD; mem_rd_req never high outside RDn.

Reset
REQ-033 reset=1 at edge: state IDLE, all outputs 0, desc_line 0, counter 0; overrides any operation incl. mid-read (mem_rd_req drops at that edge).

Configuration
REQ-034 ADMA_ALIGN_CHECK_EN defined: fetch_req with fetch_addr[2:0]!=0 goes IDLE->ERR with no memory access.
REQ-035 ADMA_ALIGN_CHECK_EN undefined: fetch_addr[2:0] forced to 0 on capture, no error.

Structure
REQ-036 Package adma_pkg: DESC_W=96, field bit positions, ACT codes (NOP 00, RSV 01, TRAN 10, LINK 11), state encodings.
REQ-037 Sub-module adma_desc_parse: combinational desc_line -> field outputs, reused by the ADMA engine.

Verification
REQ-038 Zero-wait, addr 0x1000, words 0x0010_0021/0x8000_0000/0x0000_0001 -> mem_addr 0x1000,0x1004,0x1008; desc_valid cycle 4; act=10, end=0, attr_valid=1, len=0x0010, adr=0x1_8000_0000.
REQ-039 3-cycle ack delay per word, desc_ready low 5 cycles -> outputs stable, one transfer, IDLE after handshake.
REQ-040 mem_err with ack on RD1 -> fetch_error one cycle, desc_valid never 1, IDLE.
REQ-041 No ack, TIMEOUT_CYCLES=4 -> fetch_error 4 cycles after RD0 entry; addr 0xFFFF_FFFF_FFFF_FFF8 -> mem_addr wraps to 0x0.
REQ-042 Abort in RD2, reset in RD1 -> IDLE next cycle, no error, all outputs 0; addr 0x1004 errors only with ADMA_ALIGN_CHECK_EN.
